// File: rtl/lm_sm_sequencer_if.sv
// Decode/memory/register-bank bus of the LM/SM sequencer.
// The sequencer uses the slave modport; the environment uses master.
interface lm_sm_sequencer_if;
  logic         start;
  logic         isStore;
  logic [7:0]   mask;
  logic [15:0]  baseAddr;
  logic [127:0] regData_R7_to_R0;
  logic [15:0]  memReadData;
  logic         busy;
  logic         memValid;
  logic         memWrite;
  logic [15:0]  memAddr;
  logic [15:0]  memWriteData;
  logic         regWriteEnable;
  logic [2:0]   regWriteAddress;
  logic [15:0]  regWriteData;
  logic         pcWriteEnable;
  logic         done;

  modport slave (
    input  start, isStore, mask, baseAddr, regData_R7_to_R0, memReadData,
    output busy, memValid, memWrite, memAddr, memWriteData,
           regWriteEnable, regWriteAddress, regWriteData, pcWriteEnable, done
  );

  modport master (
    output start, isStore, mask, baseAddr, regData_R7_to_R0, memReadData,
    input  busy, memValid, memWrite, memAddr, memWriteData,
           regWriteEnable, regWriteAddress, regWriteData, pcWriteEnable, done
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple sequencer: one register transfer per cycle, lowest mask bit first.
// Optional macro LMSM_R7_EN enables R7 (PC) transfers; without it mask bit 7 is dropped at latch.
module lm_sm_sequencer #(
  parameter int WORD_STEP = 1
) (
  input logic              clk,
  input logic              reset,
  lm_sm_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mask;
  logic [15:0]   r_base;
  logic          r_store;
  logic [127:0]  r_snap;
  logic [3:0]    r_cnt;

  logic [7:0]    w_lat_mask;
  logic [2:0]    w_idx;
  logic [7:0]    w_rem;
  logic [15:0]   w_addr;

`ifdef LMSM_R7_EN
  assign w_lat_mask = bus.mask;
`else
  assign w_lat_mask = {1'b0, bus.mask[6:0]};
`endif

  // Priority pick of the lowest remaining bit; scanning high-to-low lets the last hit win.
  always_comb begin
    w_idx = '0;
    for (int i = 7; i >= 0; i--)
      if (r_mask[i]) w_idx = 3'(i);
    w_rem = r_mask & ~(8'b1 << w_idx);
  end

  assign w_addr = r_base + 16'(WORD_STEP * int'(r_cnt));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_base  <= '0;
      r_store <= 1'b0;
      r_snap  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_mask  <= w_lat_mask;
          r_base  <= bus.baseAddr;
          r_store <= bus.isStore;
          r_snap  <= bus.regData_R7_to_R0;
          r_cnt   <= '0;
        end
        S_XFER: begin
          r_mask <= w_rem;
          r_cnt  <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    bus.busy            = (r_state != S_IDLE);
    bus.memValid        = 1'b0;
    bus.memWrite        = 1'b0;
    bus.memAddr         = '0;
    bus.memWriteData    = '0;
    bus.regWriteEnable  = 1'b0;
    bus.regWriteAddress = '0;
    bus.regWriteData    = '0;
    bus.pcWriteEnable   = 1'b0;
    bus.done            = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = (w_lat_mask != 8'd0) ? S_XFER : S_DONE;
      S_XFER: begin
        bus.memValid = 1'b1;
        bus.memAddr  = w_addr;
        if (r_store) begin
          bus.memWrite     = 1'b1;
          bus.memWriteData = r_snap[16*w_idx +: 16];
        end else begin
          bus.regWriteData = bus.memReadData;
`ifdef LMSM_R7_EN
          if (w_idx == 3'd7) bus.pcWriteEnable = 1'b1;
          else begin
            bus.regWriteEnable  = 1'b1;
            bus.regWriteAddress = w_idx;
          end
`else
          bus.regWriteEnable  = 1'b1;
          bus.regWriteAddress = w_idx;
`endif
        end
        if (w_rem == 8'd0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed self-checking bench for lm_sm_sequencer.
module tb_lm_sm_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   npass = 0;
  int   ntotal = 0;

  lm_sm_sequencer_if bus();
  lm_sm_sequencer #(.WORD_STEP(1)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Memory model: two fixed words, everything else addr ^ 0x3C3C.
  function automatic logic [15:0] memf(input logic [15:0] a);
    case (a)
      16'h0040: memf = 16'hAAAA;
      16'h0041: memf = 16'h5555;
      default:  memf = a ^ 16'h3C3C;
    endcase
  endfunction
  always_comb bus.memReadData = memf(bus.memAddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".memValid"}, 32'(bus.memValid), 0);
    chk({tag, ".memWrite"}, 32'(bus.memWrite), 0);
    chk({tag, ".memAddr"}, 32'(bus.memAddr), 0);
    chk({tag, ".memWriteData"}, 32'(bus.memWriteData), 0);
    chk({tag, ".regWE"}, 32'(bus.regWriteEnable), 0);
    chk({tag, ".regWD"}, 32'(bus.regWriteData), 0);
    chk({tag, ".pcWE"}, 32'(bus.pcWriteEnable), 0);
  endtask

  task automatic launch(input logic st, input logic [7:0] m, input logic [15:0] b);
    bus.start = 1'b1; bus.isStore = st; bus.mask = m; bus.baseAddr = b;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    logic [127:0] snap;
    int n;
    for (int i = 0; i < 8; i++) snap[16*i +: 16] = 16'h1000 + 16'(i);
    reset = 1'b1;
    bus.start = 1'b0; bus.isStore = 1'b0; bus.mask = '0; bus.baseAddr = '0;
    bus.regData_R7_to_R0 = snap;
    tick(); tick();
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.done", 32'(bus.done), 0);
    chk_quiet("rst");
    reset = 1'b0;
    tick();

    // LM mask 0x05 at 0x0040
    launch(1'b0, 8'h05, 16'h0040);
    chk("lm.c1.busy", 32'(bus.busy), 1);
    chk("lm.c1.memValid", 32'(bus.memValid), 1);
    chk("lm.c1.memWrite", 32'(bus.memWrite), 0);
    chk("lm.c1.addr", 32'(bus.memAddr), 32'h40);
    chk("lm.c1.regWE", 32'(bus.regWriteEnable), 1);
    chk("lm.c1.regWA", 32'(bus.regWriteAddress), 0);
    chk("lm.c1.regWD", 32'(bus.regWriteData), 32'hAAAA);
    chk("lm.c1.pcWE", 32'(bus.pcWriteEnable), 0);
    tick();
    chk("lm.c2.addr", 32'(bus.memAddr), 32'h41);
    chk("lm.c2.regWE", 32'(bus.regWriteEnable), 1);
    chk("lm.c2.regWA", 32'(bus.regWriteAddress), 2);
    chk("lm.c2.regWD", 32'(bus.regWriteData), 32'h5555);
    chk("lm.c2.done", 32'(bus.done), 0);
    tick();
    chk("lm.c3.done", 32'(bus.done), 1);
    chk("lm.c3.busy", 32'(bus.busy), 1);
    chk_quiet("lm.c3");
    tick();
    chk("lm.c4.busy", 32'(bus.busy), 0);
    chk("lm.c4.done", 32'(bus.done), 0);

    // SM mask 0xFF: 7 stores without R7 support, 8 with it
`ifdef LMSM_R7_EN
    n = 8;
`else
    n = 7;
`endif
    launch(1'b1, 8'hFF, 16'h0040);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("sm.%0d.memValid", k), 32'(bus.memValid), 1);
      chk($sformatf("sm.%0d.memWrite", k), 32'(bus.memWrite), 1);
      chk($sformatf("sm.%0d.addr", k), 32'(bus.memAddr), 32'h40 + 32'(k));
      chk($sformatf("sm.%0d.data", k), 32'(bus.memWriteData), 32'h1000 + 32'(k));
      chk($sformatf("sm.%0d.regWE", k), 32'(bus.regWriteEnable), 0);
      tick();
    end
    chk("sm.done", 32'(bus.done), 1);
    chk("sm.done.memValid", 32'(bus.memValid), 0);
    tick();
    chk("sm.idle.busy", 32'(bus.busy), 0);

    // Empty mask
    launch(1'b1, 8'h00, 16'h0040);
    chk("m0.c1.done", 32'(bus.done), 1);
    chk("m0.c1.memValid", 32'(bus.memValid), 0);
    tick();
    chk("m0.c2.busy", 32'(bus.busy), 0);
    chk("m0.c2.done", 32'(bus.done), 0);

    // Address wrap
    launch(1'b0, 8'h03, 16'hFFFF);
    chk("wrap.c1.addr", 32'(bus.memAddr), 32'hFFFF);
    chk("wrap.c1.regWD", 32'(bus.regWriteData), 32'hC3C3);
    tick();
    chk("wrap.c2.addr", 32'(bus.memAddr), 32'h0000);
    chk("wrap.c2.regWA", 32'(bus.regWriteAddress), 1);
    chk("wrap.c2.regWD", 32'(bus.regWriteData), 32'h3C3C);
    tick();
    chk("wrap.done", 32'(bus.done), 1);
    tick();

    // R7 load
    launch(1'b0, 8'h80, 16'h0010);
`ifdef LMSM_R7_EN
    chk("r7.pcWE", 32'(bus.pcWriteEnable), 1);
    chk("r7.regWE", 32'(bus.regWriteEnable), 0);
    chk("r7.regWD", 32'(bus.regWriteData), 32'h3C2C);
    tick();
`else
    chk("r7.pcWE", 32'(bus.pcWriteEnable), 0);
    chk("r7.memValid", 32'(bus.memValid), 0);
`endif
    chk("r7.done", 32'(bus.done), 1);
    tick();

    // Start held high, inputs changed mid-transfer, then reset in 2nd transfer
    bus.start = 1'b1; bus.isStore = 1'b0; bus.mask = 8'h0E; bus.baseAddr = 16'h0100;
    tick();
    chk("hold.c1.addr", 32'(bus.memAddr), 32'h100);
    chk("hold.c1.regWA", 32'(bus.regWriteAddress), 1);
    bus.mask = 8'h01; bus.baseAddr = 16'h0200; bus.isStore = 1'b1;
    tick();
    chk("hold.c2.addr", 32'(bus.memAddr), 32'h101);
    chk("hold.c2.regWA", 32'(bus.regWriteAddress), 2);
    chk("hold.c2.memWrite", 32'(bus.memWrite), 0);
    bus.start = 1'b0;
    reset = 1'b1;
    tick();
    chk("abort.busy", 32'(bus.busy), 0);
    chk("abort.done", 32'(bus.done), 0);
    chk_quiet("abort");
    reset = 1'b0;
    tick();
    chk("abort.post.busy", 32'(bus.busy), 0);
    chk("abort.post.done", 32'(bus.done), 0);
    chk("abort.post.memValid", 32'(bus.memValid), 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
